// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore control FSM for a classic multicycle MIPS-style datapath. Each
// instruction walks FETCH -> DECODE -> class-specific states -> FETCH.
// FETCH, MEMREAD and MEMWRITE wait on MemReady.
//
// Optional feature: define MULTICYCLE_JUMP_EN to decode OP_J into the JUMP
// state. Without it, OP_J is handled as an illegal opcode and the JUMP state
// does not exist.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset; forces FETCH
//   Opcode[5:0]  instruction bits [31:26]; sampled in DECODE and MEMADR only
//   MemReady     memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   RegWrite, RegDst, ALUSrcA   datapath strobes/selects
//   ALUOp1, ALUOp2  ALU class: 00 add, 01 sub, 10 funct decode
//   ALUSrcB[1:0]    00 reg, 01 const 4, 10 sign-ext imm, 11 shifted imm
//   PCSource[1:0]   00 ALU, 01 ALUOut, 10 jump target
//   IllegalOp       one-cycle flag in DECODE for an undecodable opcode
//   State[3:0]      current state encoding, for debug
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic       ALUOp1,
    output logic       ALUOp2,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam int unsigned STATE_W = 4;

`ifdef MULTICYCLE_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8
`ifdef MULTICYCLE_JUMP_EN
        ,
        S_JUMP     = 4'd9
`endif
    } state_e;

    state_e state_q;
    state_e state_d;
    state_e cur_state;

    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic op_legal;

    // Opcode class decode
    always_comb begin
        is_rtype = (Opcode == OP_RTYPE);
        is_lw    = (Opcode == OP_LW);
        is_sw    = (Opcode == OP_SW);
        is_beq   = (Opcode == OP_BEQ);
        is_j     = (Opcode == OP_J);
        op_legal = is_rtype | is_lw | is_sw | is_beq | (JUMP_EN & is_j);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_lw || is_sw)   state_d = S_MEMADR;
                else if (is_rtype)    state_d = S_EXECUTE;
                else if (is_beq)      state_d = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                else if (is_j)        state_d = S_JUMP;
`endif
                else                  state_d = S_FETCH;
            end
            S_MEMADR: begin
                // An opcode that is neither lw nor sw here abandons the access
                if (is_lw)            state_d = S_MEMREAD;
                else if (is_sw)       state_d = S_MEMWRITE;
                else                  state_d = S_FETCH;
            end
            S_MEMREAD: begin
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP:     state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // While rst is high the outputs already show FETCH, so an abandoned
    // instruction never issues a write in the reset cycle.
    always_comb begin
        cur_state = rst ? S_FETCH : state_q;
    end

    // Moore output decode
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUOp1      = 1'b0;
        ALUOp2      = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        IllegalOp   = 1'b0;
        State       = 4'(cur_state);
        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b11;
                IllegalOp = ~op_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp1  = 1'b1;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp2      = 1'b1;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule
